accum_feeder: RTL

ACCUM_FEEDER -- requirements
Module: accum_feeder

---
 rtl/accum_feeder_if.sv | 27 ++
 rtl/accum_feeder.sv | 136 +++++++++++++
 2 files changed

// File: rtl/accum_feeder_if.sv
// Handshake bundle for accum_feeder: upstream sample stream in, accumulator feed
// and frame status out.
interface accum_feeder_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] acc_data;
    logic              acc_enable;
    logic              frame_done;
    logic [7:0]        sample_cnt;
    logic [LVL_W-1:0]  fifo_level;

    modport master (
        output in_data, in_valid,
        input  in_ready, acc_data, acc_enable, frame_done, sample_cnt, fifo_level
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, acc_data, acc_enable, frame_done, sample_cnt, fifo_level
    );
endinterface

// File: rtl/accum_feeder.sv
// Buffers upstream samples in a small FIFO and feeds them to an accumulator one
// per cycle, inserting a one-cycle frame_done bubble after every FRAME_LEN samples.
module accum_feeder #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned FRAME_LEN = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    accum_feeder_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q,    state_d;
    logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [LVL_W-1:0]  level_q,    level_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [DATA_W-1:0] acc_data_q, acc_data_d;
    logic              acc_en_q,   acc_en_d;
    logic              done_q,     done_d;
    logic              ready_q,    ready_d;
    logic              push;
    logic              pop;

    logic [DATA_W-1:0] mem [DEPTH];

    // Next-state, FIFO bookkeeping and registered-output decode.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        cnt_d      = cnt_q;
        acc_data_d = acc_data_q;
        acc_en_d   = 1'b0;
        done_d     = 1'b0;
        ready_d    = ready_q;
        push       = bus.in_valid && ready_q;
        pop        = 1'b0;

        case (state_q)
            IDLE: begin
                if (push || (level_q != '0)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (level_q != '0) begin
                    pop = 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = (level_q != '0) ? RUN : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pop) begin
            acc_en_d   = 1'b1;
            acc_data_d = mem[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        // A simultaneous push and pop leaves the level where it is.
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        ready_d = (level_d < FULL_LVL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            cnt_q      <= '0;
            acc_data_q <= '0;
            acc_en_q   <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            cnt_q      <= cnt_d;
            acc_data_q <= acc_data_d;
            acc_en_q   <= acc_en_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    // Storage needs no reset: occupancy is defined by the pointers and level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.in_data;
        end
    end

    assign bus.in_ready   = ready_q;
    assign bus.acc_data   = acc_data_q;
    assign bus.acc_enable = acc_en_q;
    assign bus.frame_done = done_q;
    assign bus.sample_cnt = cnt_q;
    assign bus.fifo_level = level_q;

endmodule
